muldiv_ctrl: RTL and testbench

- Sequencer for the HI/LO multiply/divide resource behind the MULT, DIV, MFHI and MFLO ALU encodings. The decoder's hien/loen pair drives this block's start strobe.
- Runs signed multiply or divide iteratively over WIDTH cycles and owns the HI/LO registers.
- Tells the pipeline hazard logic when to stall: MFHI/MFLO, or a new MULT/DIV, issued while an operation is in flight.

---
 rtl/muldiv_ctrl.sv | 179 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : HI/LO multiply/divide sequencer. Runs a signed MULT or DIV
//                iteratively over WIDTH cycles (shift-add / restoring
//                shift-subtract on magnitudes), applies sign correction in a
//                single FIX cycle, owns HI/LO and raises the pipeline stall.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isdiv,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             rdhi,
    input  logic             rdlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       opa_q, opa_d;      // |srca|
    logic [WIDTH-1:0]       opb_q, opb_d;      // |srcb|
    logic                   sa_q, sa_d;        // sign of srca
    logic                   sb_q, sb_d;        // sign of srcb
    logic                   div_q, div_d;      // operation is DIV
    logic [2*WIDTH-1:0]     acc_q, acc_d;      // {upper partial, lower shift reg}
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;

    // Operand magnitudes taken at accept time. The most-negative value maps
    // onto itself, which is its correct unsigned magnitude.
    logic [WIDTH-1:0]       abs_a, abs_b;
    assign abs_a = srca[WIDTH-1] ? -srca : srca;
    assign abs_b = srcb[WIDTH-1] ? -srcb : srcb;

    // Multiply step: the multiplier sits in the low half and is consumed LSB
    // first; the multiplicand is added into the upper half, then all shifts right.
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: the dividend sits in the low half and is shifted MSB first
    // into the remainder; quotient bits enter at the bottom. The trial
    // difference needs one extra bit because the shifted remainder can exceed
    // WIDTH bits before the subtraction.
    logic [WIDTH:0]         rem_sh;
    logic [WIDTH:0]         div_diff;
    logic                   div_ok;
    logic [2*WIDTH-1:0]     div_next;
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, opb_q};
    assign div_ok   = ~div_diff[WIDTH];
    assign div_next = {(div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ok};

    // Sign correction applied in FIX. The overflow divide (most-negative / -1)
    // falls out naturally: magnitude quotient 2^(W-1) negates onto itself and
    // the remainder is zero.
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix, dvd_raw;
    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign dvd_raw  = sa_q ? -opa_q : opa_q;

    // Next-state, datapath next values and status outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = abs_a;
                    opb_d   = abs_b;
                    sa_d    = srca[WIDTH-1];
                    sb_d    = srcb[WIDTH-1];
                    div_d   = isdiv;
                    acc_d   = {{WIDTH{1'b0}}, (isdiv ? abs_a : abs_b)};
                    cnt_d   = CNT_LAST;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                acc_d = div_q ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FIX: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
                if (!div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (opb_q == '0) begin
                    // Divide by zero: no trap, fixed result pattern.
                    lo_d = '1;
                    hi_d = dvd_raw;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stall = busy & (rdhi | rdlo | start);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_ctrl
//  Description : Self-checking bench for muldiv_ctrl: directed corner cases,
//                hazard/stall timing and randomized MULT/DIV against a signed
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         isdiv;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         rdhi;
    logic         rdlo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .isdiv (isdiv),
        .srca  (srca),
        .srcb  (srcb),
        .rdhi  (rdhi),
        .rdlo  (rdlo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi, lo} from signed arithmetic.
    function automatic logic [63:0] model(input logic d, input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        longint p;
        int     sa;
        int     sb;
        int     q;
        int     r;
        if (!d) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            p  = pa * pb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation in the current IDLE cycle (cycle 0) and follows it
    // to cycle W+2, checking latency, busy window, HI/LO stability and result.
    task automatic run_op(input string tag, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input bit rd);
        logic [63:0] exp;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          done_cyc;
        int          done_cnt;
        bit          busy_ok;
        bit          hold_ok;
        exp      = model(d, a, b);
        old_hi   = hi;
        old_lo   = lo;
        done_cyc = -1;
        done_cnt = 0;
        busy_ok  = 1'b1;
        hold_ok  = 1'b1;
        start = 1'b1; isdiv = d; srca = a; srcb = b; rdlo = rd; rdhi = rd;
        #2;
        chk({tag, "_stall_c0"}, {63'd0, stall}, 64'd0);
        if (rd) chk({tag, "_oldlo_c0"}, {32'd0, lo}, {32'd0, old_lo});
        for (int k = 1; k <= W + 2; k++) begin
            next_cycle();
            start = 1'b0; rdlo = 1'b0; rdhi = 1'b0;
            #2;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (k <= W + 1) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
            end
        end
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(W + 1));
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_window"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, "_hilo_hold"}, {63'd0, hold_ok}, 64'd1);
        chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        chk({tag, "_result"}, {hi, lo}, exp);
    endtask

    initial begin
        bit          stall_ok;
        bit          done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rd_div;

        reset = 1'b1; start = 1'b0; isdiv = 1'b0;
        srca = '0; srcb = '0; rdhi = 1'b0; rdlo = 1'b0;

        // Reset state.
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #2;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, stall}, 64'd0);

        // Reset in the middle of MULT 7 x 9.
        next_cycle();
        start = 1'b1; isdiv = 1'b0; srca = 32'd7; srcb = 32'd9;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            start = 1'b0;
            if (k == 10) reset = 1'b1;
        end
        next_cycle();
        reset = 1'b0;
        #2;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            #2;
            if (done) done_seen = 1'b1;
        end
        chk("midrst_nodone", {63'd0, done_seen}, 64'd0);
        chk("midrst_hilo_after", {hi, lo}, 64'd0);

        // Directed operations.
        next_cycle();
        run_op("mul_m1x3", 1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0);
        chk("mul_m1x3_dir", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_m7d2_dir", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_7dm2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        chk("div_7dm2_dir", {hi, lo}, {32'd1, 32'hFFFF_FFFD});
        run_op("div_5d0", 1'b1, 32'd5, 32'd0, 1'b0);
        chk("div_5d0_dir", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_dir", {hi, lo}, {32'd0, 32'h8000_0000});

        // Hazards: MULT 6 x 7, rdlo from cycle 2, start held from cycle 5.
        start = 1'b1; isdiv = 1'b0; srca = 32'd6; srcb = 32'd7;
        stall_ok = 1'b1;
        for (int k = 1; k <= W + 36; k++) begin
            next_cycle();
            start = (k >= 5 && k <= W + 2);
            rdlo  = (k >= 2 && k <= W + 2);
            #2;
            if (k >= 2 && k <= W + 1 && stall !== 1'b1) stall_ok = 1'b0;
            if (k == W + 2) begin
                chk("haz_stall_release", {63'd0, stall}, 64'd0);
                chk("haz_lo_read", {32'd0, lo}, 64'd42);
                chk("haz_idle", {63'd0, busy}, 64'd0);
            end
            if (k == W + 3) chk("haz_held_accept", {63'd0, busy}, 64'd1);
        end
        chk("haz_stall_window", {63'd0, stall_ok}, 64'd1);
        chk("haz_second_result", {hi, lo}, {32'd0, 32'd42});

        // Same-cycle read and start: DIV 10 / 3 with rdlo.
        run_op("div_10d3_rd", 1'b1, 32'd10, 32'd3, 1'b1);
        chk("div_10d3_dir", {hi, lo}, {32'd1, 32'd3});

        // Randomized operations against the reference model.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin
                    ra = 32'($signed($urandom_range(0, 40)) - 20);
                    rb = 32'($signed($urandom_range(0, 40)) - 20);
                end
                2: begin ra = 32'h8000_0000; rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
                default: begin ra = $urandom; rb = 32'($signed($urandom_range(0, 6)) - 3); end
            endcase
            rd_div = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", n), rd_div, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
